ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xF4 enable reporting, 0xF3/0xC8 sample-rate writes for wheel enable) to the mouse over the shared open-drain PS2 clock/data lines, then checks the device ACK. It sits beside the PS/2 mouse receiver. Its inhibit/request-to-send sequence holds the receiver idle while a command is in flight.

Parameters:
INHIBIT_CYCLES, 12000, CLK cycles the PS2 clock is held low before request-to-send (≥100 µs at 100 MHz).
RTS_CYCLES, 16, CLK cycles PS2 clock and data are both held low before the PS2 clock is released.
TIMEOUT_CYCLES, 200000, maximum CLK cycles allowed between device clock falling edges (2 ms).
FILTER_LEN, 8, stability length of the clock glitch filter (used only with PS2_CLK_FILTER_EN).

Ports:
CLK  input  1  system clock.
RESET  input  1  asynchronous, active-low reset.
tx_data  input  8  command byte; sampled on the accepted tx_start.
tx_start  input  1  request pulse; accepted only when busy=0.
busy  output  1  high from the cycle after acceptance until the return to IDLE.
done  output  1  one-cycle pulse: byte sent and ACK received.
error  output  1  one-cycle pulse: NACK or timeout.
ps2_clk_in  input  1  PS2 clock line level (asynchronous).
ps2_data_in  input  1  PS2 data line level (asynchronous).
ps2_clk_oe  output  1  1 = drive PS2 clock low, 0 = release.
ps2_data_oe  output  1  1 = drive PS2 data low, 0 = release.

Behaviour:
- Reset (asynchronous, RESET=0): state IDLE; busy, done, error, ps2_clk_oe and ps2_data_oe all 0; counters cleared. Reset mid-transfer releases both lines immediately.
- Synchronisation: ps2_clk_in and ps2_data_in each pass through 2 flip-flops. fall = previous synchronised clock 1 and current 0, one-cycle strobe.
- IDLE: on tx_start, latch tx_data and compute parity = ~^tx_data (odd parity). Next cycle: INHIBIT, busy=1, ps2_clk_oe=1.
- INHIBIT: hold ps2_clk_oe=1 and ps2_data_oe=0 for INHIBIT_CYCLES cycles, then go to RTS.
- RTS: ps2_clk_oe=1, ps2_data_oe=1 (start bit = 0) for RTS_CYCLES cycles. Then release ps2_clk_oe, clear bit index and timeout counter, and go to SEND.
- SEND: on each fall, bit index k advances 0..9:
  - k=0..7: ps2_data_oe = ~tx_data[k] (LSB first).
  - k=8: ps2_data_oe = ~parity.
  - k=9: ps2_data_oe = 0 (stop bit, line released).
  - After the k=9 edge, go to ACK.
- ACK: on the next fall, sample synchronised data. 0 → WAIT_RELEASE. 1 → error pulse, go to IDLE.
- WAIT_RELEASE: wait until synchronised clock and data are both 1. Then pulse done for one cycle and go to IDLE, with busy=0 in the same cycle.
- Timeout: in SEND/ACK/WAIT_RELEASE the counter clears on every fall. When it reaches TIMEOUT_CYCLES: release both lines, pulse error, go to IDLE.
- tx_start while busy=1 is ignored: the latched byte is unchanged and no queueing occurs.
- done and error are never high in the same cycle.
- Counter widths are $clog2 of the largest count parameter plus 1. No wrap is possible before the compare.

Optional Feature:
PS2_CLK_FILTER_EN:
- Defined: the synchronised PS2 clock feeds a filter whose output changes only after the input has held the new level for FILTER_LEN consecutive CLK cycles. fall is derived from the filter output, so glitches shorter than FILTER_LEN are ignored. Latency from a line edge to fall becomes 2+FILTER_LEN cycles.
- Undefined: fall is taken directly from the 2-FF synchroniser, with 2-3 cycle latency.

Test Plan:
- Sim params INHIBIT=20, RTS=4, TIMEOUT=500; device model clocks at 40-cycle period. tx_data=0xF4 → ps2_clk_oe high 20 cycles; both oe high 4 cycles; ps2_data_oe across edges k0..9 = 1,1,0,1,0,0,0,0,1,0; model ACKs → done pulses once, busy falls.
- tx_data=0x00 → parity edge (k=8) has ps2_data_oe=0; ACK low → done=1, error=0.
- Model leaves data high on the 11th clock → error pulses once, done stays 0, both oe=0, state IDLE.
- Model never clocks after RTS → error at exactly 500 cycles after the clock release, both lines released.
- tx_start with 0x55 issued mid-SEND of 0xF4 → transfer continues bit-exact for 0xF4, and no second transfer follows.
- RESET=0 at k=4 → ps2_clk_oe, ps2_data_oe and busy are 0 within the same cycle; after release a new tx_start works normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 bits clocked by the device, ACK check.
// Optional macro PS2_CLK_FILTER_EN adds a FILTER_LEN-cycle stability filter on the synchronised PS2 clock.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int RTS_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);
   localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
   localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int CW    = $clog2(MAX_C) + 1;

   typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_REL} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    idx, idx_n;
   logic [7:0]    data_r, data_n;
   logic          par_r, par_n, doe_r, doe_n, done_n, err_n;
   logic [1:0]    clk_sync, data_sync;
   logic          clk_s, data_s, clk_f, clk_prev, fall;

   // Sync flops reset high so the idle bus produces no spurious edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
         clk_prev  <= clk_f;
      end
   end
   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

`ifdef PS2_CLK_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN) + 1;
   logic [FW-1:0] fcnt;
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         clk_f <= 1'b1;
         fcnt  <= '0;
      end else if (clk_s == clk_f) begin
         fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
         clk_f <= clk_s;
         fcnt  <= '0;
      end else begin
         fcnt <= fcnt + FW'(1);
      end
   end
`else
   assign clk_f = clk_s;
`endif

   assign fall = clk_prev & ~clk_f;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= S_IDLE;
         cnt    <= '0;
         idx    <= '0;
         data_r <= '0;
         par_r  <= 1'b0;
         doe_r  <= 1'b0;
         done   <= 1'b0;
         error  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         data_r <= data_n;
         par_r  <= par_n;
         doe_r  <= doe_n;
         done   <= done_n;
         error  <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      data_n  = data_r;
      par_n   = par_r;
      doe_n   = doe_r;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_n = '0;
            doe_n = 1'b0;
            if (tx_start) begin
               data_n  = tx_data;
               par_n   = ~^tx_data;
               state_n = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
               cnt_n   = '0;
               state_n = S_RTS;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_RTS: begin
            doe_n = 1'b1;
            if (cnt == CW'(RTS_CYCLES - 1)) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = S_SEND;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            // SEND / ACK / WAIT_REL share the inter-edge timeout.
            if (fall) begin
               cnt_n = '0;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               cnt_n   = '0;
               doe_n   = 1'b0;
               err_n   = 1'b1;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
            if (state == S_SEND && fall) begin
               if (idx < 4'd8)       doe_n = ~data_r[idx[2:0]];
               else if (idx == 4'd8) doe_n = ~par_r;
               else                  doe_n = 1'b0;
               if (idx == 4'd9) state_n = S_ACK;
               else             idx_n   = idx + 4'd1;
            end
            if (state == S_ACK && fall) begin
               if (data_s) begin
                  err_n   = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  state_n = S_WAIT_REL;
               end
            end
            if (state == S_WAIT_REL && clk_s && data_s) begin
               err_n   = 1'b0;
               done_n  = 1'b1;
               state_n = S_IDLE;
            end
         end
      endcase
   end

   assign busy        = (state != S_IDLE);
   assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_RTS);
   assign ps2_data_oe = (state == S_RTS) || ((state == S_SEND) && doe_r);
endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: device model on the open-drain lines, monitor checks each done/error.
module tb_ps2_host_tx;
   localparam int INH = 20;
   localparam int RTS = 4;
   localparam int TO  = 500;

   logic       CLK = 1'b0, RESET = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       busy, done, error, ps2_clk_oe, ps2_data_oe;
   logic       dev_clk = 1'b1, dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in;

   // Wired-AND open-drain bus
   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .RESET(RESET), .tx_data(tx_data), .tx_start(tx_start),
      .busy(busy), .done(done), .error(error),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [9:0] bits;
      bit         chk_bits;
      bit         exp_done;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [9:0] obs_bits;
   int         total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: frame bit k shows as oe=1 when the bit is 0; odd parity makes the parity bit 1 for an even count of ones.
   function automatic logic [9:0] exp_bits(input logic [7:0] d);
      logic [9:0] b;
      int ones;
      ones = 0;
      for (int k = 0; k < 8; k++) begin
         b[k] = (d[k] == 1'b0);
         ones += int'(d[k]);
      end
      b[8] = (ones % 2 == 1);
      b[9] = 1'b0;
      return b;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // mode: 0 ACK, 1 NACK, 2 device silent, 3 reset mid-frame at k=4
   task automatic start(input logic [7:0] d, input int mode);
      exp_t e;
      @(negedge CLK);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge CLK);
      tx_start = 1'b0;
      e.bits     = (mode == 2) ? 10'd0 : exp_bits(d);
      e.chk_bits = (mode != 2);
      e.exp_done = (mode == 0);
      if (mode != 3) sb.push_back(e);
   endtask

   task automatic run_device(input int mode, output int n_inh, output int n_rts, output int n_to);
      int n;
      n_inh = 0; n_rts = 0; n_to = 0;
      while (ps2_clk_oe && !ps2_data_oe && n_inh < 1000) begin n_inh++; @(negedge CLK); end
      while (ps2_clk_oe && ps2_data_oe && n_rts < 1000) begin n_rts++; @(negedge CLK); end
      if (mode == 2) begin
         while (!error && n_to < 2000) begin @(negedge CLK); n_to++; end
         return;
      end
      cyc(5);
      for (int i = 1; i <= 11; i++) begin
         if (i == 11 && mode == 0) begin dev_data = 1'b0; cyc(5); end
         dev_clk = 1'b0;
         cyc(16);
         if (i <= 10) obs_bits[i-1] = ps2_data_oe;
         if (mode == 3 && i == 5) begin
            chk("oe_before_reset", ps2_data_oe, 1);
            #2 RESET = 1'b0;
            #1;
            chk("rst_clk_oe", ps2_clk_oe, 0);
            chk("rst_data_oe", ps2_data_oe, 0);
            chk("rst_busy", busy, 0);
            dev_clk = 1'b1;
            cyc(3);
            RESET = 1'b1;
            cyc(3);
            return;
         end
         cyc(4);
         dev_clk  = 1'b1;
         dev_data = 1'b1;
         cyc(20);
      end
      n = 0;
      while (busy && n < 200) begin @(negedge CLK); n++; end
      chk("end_of_txn_timeout", busy, 0);
   endtask

   // Monitor: pops an expectation whenever the DUT reports completion.
   always @(negedge CLK) begin
      if (RESET && (done || error)) begin
         chk("done_and_error", done & error, 0);
         chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
         chk("busy_at_end", busy, 0);
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_end: done=%0b error=%0b with empty scoreboard", done, error);
         end else begin
            mon_e = sb.pop_front();
            chk("done", done, mon_e.exp_done);
            chk("error", error, !mon_e.exp_done);
            if (mon_e.chk_bits) chk("frame_bits", obs_bits, mon_e.bits);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int inh, rts, tmo, cnt;
      logic [7:0] d;
      int m;
      RESET = 1'b0;
      cyc(3);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      RESET = 1'b1;
      cyc(3);

      // 0xF4 with an ignored 0x55 request issued mid-frame
      start(8'hF4, 0);
      fork
         begin
            cyc(150);
            tx_data  = 8'h55;
            tx_start = 1'b1;
            cyc(1);
            tx_start = 1'b0;
         end
      join_none
      run_device(0, inh, rts, tmo);
      chk("inhibit_len", inh, INH);
      chk("rts_len", rts, RTS);
      chk("f4_bits", obs_bits, 10'b01_0000_1011);
      cnt = 0;
      repeat (200) begin @(negedge CLK); if (ps2_clk_oe || busy) cnt++; end
      chk("no_second_txn", cnt, 0);

      // 0x00: parity edge drives nothing
      start(8'h00, 0);
      run_device(0, inh, rts, tmo);
      chk("parity_00", obs_bits[8], 0);
      cyc(10);

      // NACK
      d = 8'($urandom_range(0, 255));
      start(d, 1);
      run_device(1, inh, rts, tmo);
      cyc(10);

      // silent device
      start(8'hF3, 2);
      run_device(2, inh, rts, tmo);
      chk("timeout_len", tmo, TO);
      cyc(10);

      // reset mid-frame, then a normal transfer
      start(8'h00, 3);
      run_device(3, inh, rts, tmo);
      start(8'hC8, 0);
      run_device(0, inh, rts, tmo);
      cyc(10);

      for (int t = 0; t < 8; t++) begin
         d = 8'($urandom_range(0, 255));
         m = int'($urandom_range(0, 1));
         start(d, m);
         run_device(m, inh, rts, tmo);
         cyc(int'($urandom_range(2, 20)));
      end

      cyc(20);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
